// File: rtl/jtdd_romarb_pkg.sv
// Shared types and helpers for the jtdd ROM arbiter.
// State encoding, SDRAM address width and slot line-tag extraction.
package jtdd_romarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } romarb_state_t;

    localparam int SDRAM_AW = 22;

    // A cache line is 32 bits: two 16-bit words or four bytes
    function automatic logic [31:0] slot_tag(
        input logic [31:0] addr,
        input logic        dw16
    );
        return dw16 ? (addr >> 1) : (addr >> 2);
    endfunction

endpackage

// File: rtl/jtdd_romarb_slot.sv
// One ROM read slot: single-line 32-bit cache, tag compare,
// word/byte select, miss (pending) flag and registered data/ok.
module jtdd_romarb_slot
    import jtdd_romarb_pkg::*;
#(
    parameter int                    AW     = 18,
    parameter bit                    DW16   = 1'b0,
    parameter logic [SDRAM_AW-1:0]   OFFSET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic [AW-1:0]       addr,
    input  logic                inval,
    input  logic                fill,
    input  logic [AW-1:0]       fill_tag,
    input  logic [31:0]         fill_data,
    output logic                pending,
    output logic [AW-1:0]       tag,
    output logic [SDRAM_AW-1:0] req_addr,
    output logic [15:0]         dout,
    output logic                ok
);

    logic [31:0]   line;
    logic [AW-1:0] line_tag;
    logic          valid;
    logic          hit;
    logic [15:0]   word;
    logic [15:0]   sel;

    assign tag      = AW'(slot_tag(32'(addr), DW16));
    assign hit      = cs && valid && (line_tag == tag) && !inval;
    assign pending  = cs && !(valid && (line_tag == tag)) && !inval;
    assign req_addr = (OFFSET & ~SDRAM_AW'(1))
                    + SDRAM_AW'({tag, 1'b0});

    // Pick the addressed word, then the byte for 8-bit slots
    always_comb begin
        word = '0;
        sel  = '0;
        if (DW16 ? addr[0] : addr[1])
            word = line[31:16];
        else
            word = line[15:0];
        if (DW16)
            sel = word;
        else
            sel = {8'h00, addr[0] ? word[15:8] : word[7:0]};
    end

    // Cache line storage; invalidation beats a fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line     <= '0;
            line_tag <= '0;
            valid    <= 1'b0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            line     <= fill_data;
            line_tag <= fill_tag;
            valid    <= 1'b1;
        end
    end

    // One-cycle registered hit data and ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok   <= 1'b0;
            dout <= '0;
        end else begin
            ok   <= hit;
            dout <= hit ? sel : 16'h0000;
        end
    end

endmodule

// File: rtl/jtdd_rom_arbiter.sv
// N cached ROM read slots sharing one SDRAM read port.
// Define JTDD_ROMARB_RR_EN for round-robin instead of fixed priority.
module jtdd_rom_arbiter
    import jtdd_romarb_pkg::*;
#(
    parameter int                         SLOTS       = 4,
    parameter int                         AW          = 18,
    parameter logic [SLOTS-1:0]           SLOT_DW16   = '0,
    parameter logic [SLOTS*SDRAM_AW-1:0]  SLOT_OFFSET = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic                  loop_rst,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS*16-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    output logic                  sdram_req,
    output logic [SDRAM_AW-1:0]   sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [31:0]           data_read,
    output logic                  refresh_en,
    output logic                  busy
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    romarb_state_t       state, state_nx;
    logic [SLOTS-1:0]    pending;
    logic [SLOTS-1:0]    fill;
    logic [AW-1:0]       tag_arr  [SLOTS];
    logic [SDRAM_AW-1:0] addr_arr [SLOTS];
    logic [IW-1:0]       grant;
    logic [IW-1:0]       winner;
    logic [AW-1:0]       fill_tag;
    logic                inval;
    logic                alive;

    assign inval = downloading | loop_rst;

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        jtdd_romarb_slot #(
            .AW     (AW),
            .DW16   (SLOT_DW16[gi]),
            .OFFSET (SLOT_OFFSET[gi*SDRAM_AW +: SDRAM_AW])
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .cs        (slot_cs[gi]),
            .addr      (slot_addr[gi*AW +: AW]),
            .inval     (inval),
            .fill      (fill[gi]),
            .fill_tag  (fill_tag),
            .fill_data (data_read),
            .pending   (pending[gi]),
            .tag       (tag_arr[gi]),
            .req_addr  (addr_arr[gi]),
            .dout      (slot_dout[gi*16 +: 16]),
            .ok        (slot_ok[gi])
        );
    end

    // Winner selection; the last hit in the loop has top priority
    always_comb begin
        grant = '0;
`ifdef JTDD_ROMARB_RR_EN
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (pending[(int'(winner) + 1 + k) % SLOTS])
                grant = IW'((int'(winner) + 1 + k) % SLOTS);
        end
`else
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pending[i])
                grant = IW'(i);
        end
`endif
    end

    // Next-state logic for the SDRAM transfer
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if ((|pending) && !inval) state_nx = ST_REQ;
            ST_REQ:  if (sdram_ack)            state_nx = ST_WAIT;
            ST_WAIT: if (data_rdy)             state_nx = ST_IDLE;
            default:                           state_nx = ST_IDLE;
        endcase
    end

    // Fill strobe to the winner; dropped while downloading/looping
    always_comb begin
        fill = '0;
        if (state == ST_WAIT && data_rdy && !inval)
            fill[winner] = 1'b1;
    end

    // State register and per-transfer latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            winner     <= '0;
            sdram_addr <= '0;
            fill_tag   <= '0;
            alive      <= 1'b0;
        end else begin
            alive <= 1'b1;
            state <= state_nx;
            if (state == ST_IDLE && state_nx == ST_REQ) begin
                winner     <= grant;
                sdram_addr <= addr_arr[grant];
                fill_tag   <= tag_arr[grant];
            end
        end
    end

    assign sdram_req  = (state == ST_REQ);
    assign busy       = (state != ST_IDLE);
    assign refresh_en = alive && (state == ST_IDLE) && !(|pending);

endmodule

// File: tb/tb_jtdd_rom_arbiter.sv
// Self-checking bench for jtdd_rom_arbiter (4 slots, mixed widths).
// Table-driven fills/hits with an expected-data queue, plus corner sequences.
module tb_jtdd_rom_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         downloading;
    logic         loop_rst;
    logic [3:0]   slot_cs;
    logic [71:0]  slot_addr;
    logic [63:0]  slot_dout;
    logic [3:0]   slot_ok;
    logic         sdram_req;
    logic [21:0]  sdram_addr;
    logic         sdram_ack;
    logic         data_rdy;
    logic [31:0]  data_read;
    logic         refresh_en;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int          slot;
        logic [17:0] addr;
        logic [31:0] data;
        logic [21:0] exp_addr;
        logic [15:0] exp_dout;
    } fill_t;

    typedef struct {
        int          slot;
        logic [17:0] addr;
        logic [15:0] exp_dout;
    } hit_t;

    fill_t fills[4];
    hit_t  hits[6];

    jtdd_rom_arbiter #(
        .SLOTS       (4),
        .AW          (18),
        .SLOT_DW16   (4'b0101),
        .SLOT_OFFSET ({22'h000000, 22'h030000, 22'h020000, 22'h010000})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_dout   (slot_dout),
        .slot_ok     (slot_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_addr(input int s, input logic [17:0] a);
        slot_addr[s*18 +: 18] = a;
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (sdram_req) seen = 1;
            else tick();
        end
        chk({name, "_req"}, 32'(seen), 32'd1);
    endtask

    task automatic do_fill(input string name, input int s,
                           input logic [17:0] a, input logic [31:0] d,
                           input logic [21:0] ea, input logic [15:0] ed);
        bit got;
        slot_cs[s] = 1'b1;
        set_addr(s, a);
        wait_req(name);
        chk({name, "_sdram_addr"}, 32'(sdram_addr), 32'(ea));
        exp_q.push_back(ed);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (slot_ok[s]) got = 1;
            else tick();
        end
        chk({name, "_ok"}, 32'(got), 32'd1);
        if (exp_q.size() > 0)
            chk({name, "_dout"}, 32'(slot_dout[s*16 +: 16]),
                32'(exp_q.pop_front()));
    endtask

    initial begin
        fills[0] = '{0, 18'h00005, 32'hBEEF1234, 22'h010004, 16'hBEEF};
        fills[1] = '{1, 18'h00003, 32'hAABBCCDD, 22'h020000, 16'h00AA};
        fills[2] = '{2, 18'h00100, 32'h55556666, 22'h030100, 16'h6666};
        fills[3] = '{3, 18'h3FFFE, 32'h11223344, 22'h01FFFE, 16'h0022};
        hits[0]  = '{0, 18'h00004, 16'h1234};
        hits[1]  = '{1, 18'h00000, 16'h00DD};
        hits[2]  = '{1, 18'h00001, 16'h00CC};
        hits[3]  = '{1, 18'h00002, 16'h00BB};
        hits[4]  = '{2, 18'h00101, 16'h5555};
        hits[5]  = '{3, 18'h3FFFD, 16'h0033};

        rst = 1'b1;
        downloading = 0; loop_rst = 0; sdram_ack = 0; data_rdy = 0;
        slot_cs = '0; slot_addr = '0; data_read = '0;
        tick();
        tick();
        chk("rst_req",     32'(sdram_req),  32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_refresh", 32'(refresh_en), 32'd0);
        chk("rst_ok",      32'(slot_ok),    32'd0);
        chk("rst_dout",    slot_dout[31:0], 32'd0);
        chk("rst_saddr",   32'(sdram_addr), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_refresh", 32'(refresh_en), 32'd1);

        for (int i = 0; i < 4; i++)
            do_fill($sformatf("fill%0d", i), fills[i].slot, fills[i].addr,
                    fills[i].data, fills[i].exp_addr, fills[i].exp_dout);

        for (int i = 0; i < 6; i++) begin
            set_addr(hits[i].slot, hits[i].addr);
            tick();
            chk($sformatf("hit%0d_ok", i),
                32'(slot_ok[hits[i].slot]), 32'd1);
            chk($sformatf("hit%0d_dout", i),
                32'(slot_dout[hits[i].slot*16 +: 16]), 32'(hits[i].exp_dout));
            chk($sformatf("hit%0d_noreq", i), 32'(sdram_req), 32'd0);
        end
        chk("hits_refresh", 32'(refresh_en), 32'd1);
        chk("hits_busy",    32'(busy),       32'd0);

        do_fill("refill0", 0, 18'h00010, 32'h0A0B0C0D, 22'h010010, 16'h0C0D);

        set_addr(0, 18'h00020);
        set_addr(2, 18'h00200);
        tick();
        chk("dual_ok0_drop", 32'(slot_ok[0]), 32'd0);
`ifdef JTDD_ROMARB_RR_EN
        do_fill("dual_s2", 2, 18'h00200, 32'h44447777, 22'h030200, 16'h7777);
        do_fill("dual_s0", 0, 18'h00020, 32'h22223333, 22'h010020, 16'h3333);
`else
        do_fill("dual_s0", 0, 18'h00020, 32'h22223333, 22'h010020, 16'h3333);
        do_fill("dual_s2", 2, 18'h00200, 32'h44447777, 22'h030200, 16'h7777);
`endif

        slot_cs = 4'b1000;
        set_addr(3, 18'h00100);
        wait_req("dl");
        chk("dl_sdram_addr", 32'(sdram_addr), 32'h80);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        downloading = 1'b1;
        data_read = 32'hDEADBEEF;
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        tick();
        chk("dl_ok",      32'(slot_ok),    32'd0);
        chk("dl_req",     32'(sdram_req),  32'd0);
        chk("dl_refresh", 32'(refresh_en), 32'd1);
        chk("dl_busy",    32'(busy),       32'd0);
        downloading = 1'b0;
        do_fill("dl_after", 3, 18'h00100, 32'h99887766, 22'h000080, 16'h0066);

        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        chk("loop_ok", 32'(slot_ok[3]), 32'd0);
        tick();
        chk("loop_req", 32'(sdram_req), 32'd1);
        do_fill("loop_fill", 3, 18'h00100, 32'h55443322, 22'h000080, 16'h0022);

        slot_cs = 4'b0001;
        set_addr(0, 18'h00040);
        wait_req("rstx");
        chk("rstx_sdram_addr", 32'(sdram_addr), 32'h010040);
        #2;
        rst = 1'b1;
        #1;
        chk("rstx_req",  32'(sdram_req), 32'd0);
        chk("rstx_busy", 32'(busy),      32'd0);
        chk("rstx_ok",   32'(slot_ok),   32'd0);
        tick();
        rst = 1'b0;
        data_read = 32'hCAFEF00D;
        data_rdy = 1'b1;
        tick();
        tick();
        data_rdy = 1'b0;
        chk("rstx_late_ok0", 32'(slot_ok), 32'd0);
        tick();
        chk("rstx_late_ok1", 32'(slot_ok), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtdd_rom_arbiter.md
Name: jtdd_rom_arbiter

Overview:
- Parametrised successor to the fixed-slot game ROM controller: N independent ROM read slots share one SDRAM read port.
- Each slot has a one-line 32-bit cache; on a miss the slot queues an SDRAM read.
- Sits between the game video/CPU ROM consumers and the SDRAM controller; replaces per-game hard-wired slot lists.

Parameters:
SLOTS, 4, number of read slots (1..8)
AW, 18, slot address width, in slot data units
SLOT_DW16, 0, packed SLOTS bits; bit i=1: slot i is 16-bit, 0: slot i is 8-bit
SLOT_OFFSET, 0, packed SLOTS×22 bits; per-slot SDRAM 16-bit-word base offset

Ports:
clk  in  1  system clock (48 MHz)
rst  in  1  asynchronous active-high reset
downloading  in  1  ROM load in progress; blocks reads
loop_rst  in  1  invalidates all caches
slot_cs  in  SLOTS  per-slot read request
slot_addr  in  SLOTS×AW  packed slot addresses, slot i at [i*AW+:AW]
slot_dout  out  SLOTS×16  packed data; 8-bit slots use [7:0], [15:8]=0
slot_ok  out  SLOTS  data valid for the current slot_addr
sdram_req  out  1  read request
sdram_addr  out  22  16-bit-word address, always even
sdram_ack  in  1  request accepted
data_rdy  in  1  data_read valid
data_read  in  32  two 16-bit words; [15:0] = even word
refresh_en  out  1  SDRAM idle, refresh allowed
busy  out  1  transfer in flight

Behaviour:
- Reset: all outputs 0; caches invalid; FSM IDLE.
- Line tag:
  - 16-bit slot: addr[AW-1:1]; word select addr[0].
  - 8-bit slot: addr[AW-1:2]; word select addr[1], byte select addr[0].
- sdram_addr = SLOT_OFFSET[i] + (line index << 1). Sum is 22-bit modulo.
- Hit: cache valid, tag == current tag, and slot_cs high.
  - Next cycle: slot_dout = selected word/byte, slot_ok = 1 (1-cycle registered latency).
  - slot_ok drops the cycle after an addr change or cs low.
- Miss: slot i raises an internal pending bit.
- FSM:
  - IDLE: if any pending and !downloading → choose winner, latch addr/tag, set sdram_req → REQ.
  - REQ: hold sdram_req and sdram_addr stable until sdram_ack; then clear req → WAIT.
  - WAIT: on data_rdy, write data_read into the winner's cache line with the latched tag, set valid → IDLE.
  - A slot with a fresh fill is evaluated for a hit the cycle after data_rdy, so miss-to-ok ≥ 3 cycles.
- Arbitration (default): fixed priority, lowest index wins.
- Mid-transfer changes:
  - slot addr changes mid-transfer: the fill still lands with the old tag; the new addr misses and re-requests.
  - cs drops mid-transfer: the transfer completes and the cache fills.
- data_rdy in IDLE/REQ: ignored. sdram_ack outside REQ: ignored.
- refresh_en = (state==IDLE) && no pending. busy = state!=IDLE.
- downloading: from IDLE, no new requests; all caches invalidated; slot_ok=0. A transfer already in REQ/WAIT completes but its data is discarded.
- loop_rst: same invalidation as downloading, for one cycle.
- Async rst mid-transfer: immediate return to reset state; a later data_rdy is ignored.

Optional Feature:
- Macro JTDD_ROMARB_RR_EN.
  - Defined: round-robin arbitration; search starts at (last winner+1) mod SLOTS.
  - Undefined: fixed priority, slot 0 highest.
- Handshake and latency are identical in both builds.

Decomposition:
- Package jtdd_romarb_pkg:
  - FSM state enum (IDLE/REQ/WAIT).
  - Constant SDRAM_AW=22.
  - Function slot_tag(addr, dw16).
- Sub-module jtdd_romarb_slot, instantiated SLOTS times by generate:
  - Holds the cache line, tag compare, byte/word select, pending bit and ok/dout registers.
  - The top module keeps the arbiter and the FSM.

Test Plan:
- Reset release, slot0 16-bit, SLOT_OFFSET0=0x10000, cs=1, addr=0x0005:
  - expect sdram_req with sdram_addr=0x10004.
  - ack, then data_rdy with data_read=0xBEEF1234 → slot_dout0=0xBEEF, slot_ok0=1.
- Same line, addr 0x0004 → 0x1234 one cycle later with no new sdram_req.
- 8-bit slot1, addr 0x3, line holds 0xAABBCCDD → slot_dout1=0x00AA.
- Slots 0 and 2 miss in the same cycle:
  - default build serves slot 0 first.
  - RR_EN build with last winner 0 serves slot 2 first.
- downloading=1 while in WAIT:
  - data_rdy is discarded, slot_ok=0, no new req, refresh_en=1.
  - after drop, a fresh miss re-requests.
- rst pulse while in REQ: sdram_req=0 immediately; a later data_rdy changes no slot_ok.
